// File: rtl/calculate_countid_pipe.sv
// Elastic priority encoder: returns the lowest or highest set index of a rule-match
// vector through a width_count-stage binary-halving pipeline with valid/ready flow control.
module calculate_countid_pipe #(
    parameter int rule_num    = 64,
    parameter int width_count = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   bv_in_valid,
    output logic                   bv_in_ready,
    input  logic [rule_num-1:0]    bv_in,
    input  logic                   mode_high,
    output logic                   countid_valid,
    input  logic                   countid_ready,
    output logic [width_count-1:0] countid,
    output logic                   countid_hit
);

    localparam int PAD = 1 << width_count;

    logic           en;
    logic [PAD-1:0] bv_pad;

    // Padded bits stay zero, so no padded index can ever be selected.
    always_comb begin
        bv_pad                 = '0;
        bv_pad[rule_num-1:0]   = bv_in;
    end

    assign en          = ~countid_valid | countid_ready;
    assign bv_in_ready = en;

    for (genvar s = width_count; s >= 1; s--) begin : g_stage
        localparam int WIN  = 1 << s;
        localparam int HALF = WIN >> 1;

        logic [WIN-1:0]         win_in;
        logic [width_count-1:0] idx_in;
        logic                   mode_in;
        logic                   hit_in;
        logic                   vld_in;
        logic                   sel_u;
        logic [width_count-1:0] idx_d;
        logic [width_count-1:0] idx_q;
        logic                   hit_q;
        logic                   vld_q;

        if (s == width_count) begin : g_src
            assign win_in  = bv_pad;
            assign idx_in  = '0;
            assign mode_in = mode_high;
            assign hit_in  = |bv_in;
            assign vld_in  = bv_in_valid;
        end else begin : g_src
            assign win_in  = g_stage[s+1].g_carry.win_q;
            assign idx_in  = g_stage[s+1].idx_q;
            assign mode_in = g_stage[s+1].g_carry.mode_q;
            assign hit_in  = g_stage[s+1].hit_q;
            assign vld_in  = g_stage[s+1].vld_q;
        end

        always_comb begin
            if (mode_in) begin
                sel_u = |win_in[WIN-1:HALF];
            end else begin
                sel_u = ~|win_in[HALF-1:0];
            end
            idx_d        = idx_in;
            idx_d[s-1]   = sel_u;
            // A miss would otherwise resolve to all-ones in low mode; report index 0.
            if (s == 1 && !hit_in) begin
                idx_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= 1'b0;
                idx_q <= '0;
                hit_q <= 1'b0;
            end else begin
                if (flush) begin
                    vld_q <= 1'b0;
                end else if (en) begin
                    vld_q <= vld_in;
                end
                if (en) begin
                    idx_q <= idx_d;
                    hit_q <= hit_in;
                end
            end
        end

        if (s > 1) begin : g_carry
            logic [HALF-1:0] win_d;
            logic [HALF-1:0] win_q;
            logic            mode_q;

            assign win_d = sel_u ? win_in[WIN-1:HALF] : win_in[HALF-1:0];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    win_q  <= '0;
                    mode_q <= 1'b0;
                end else if (en) begin
                    win_q  <= win_d;
                    mode_q <= mode_in;
                end
            end
        end
    end

    assign countid_valid = g_stage[1].vld_q;
    assign countid       = g_stage[1].idx_q;
    assign countid_hit   = g_stage[1].hit_q;

endmodule

// File: doc/calculate_countid_pipe.md
Name: calculate_countid_pipe

Overview:
- Parametrised, elastic successor to the rule-match priority encoder.
- Takes a rule-match bit vector, one bit per rule, and returns the index of the winning rule through a width_count-stage binary-halving pipeline.
- New relative to the previous generation:
  - any rule_num, not only powers of two;
  - per-transaction priority direction (lowest or highest index wins);
  - explicit hit flag;
  - valid/ready backpressure;
  - synchronous flush.
- Sits between the bit-vector AND stage and the action lookup.

Parameters:
- rule_num, 64, number of rules (bv width); any value >= 2.
- width_count, 6, index width; must satisfy 2^(width_count-1) < rule_num <= 2^width_count.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all in-flight transactions.
- bv_in_valid  input  1  bv_in/mode_high are valid.
- bv_in_ready  output  1  pipeline accepts input this cycle.
- bv_in  input  rule_num  match vector; bit k = rule k matched.
- mode_high  input  1  0: lowest set index wins; 1: highest set index wins.
- countid_valid  output  1  result valid.
- countid_ready  input  1  downstream accepts result.
- countid  output  width_count  winning rule index.
- countid_hit  output  1  at least one bit of bv_in was set.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high; it clears every stage valid bit, countid_valid=0, countid=0, countid_hit=0.
  - Data registers may also be cleared, but only the valid bits are required to be.
- Padding: bv_in is zero-extended to 2^width_count bits internally. Padded bits are never set, so a padded index can never win.
- Pipeline depth: exactly width_count register stages. Stage s (s = width_count down to 1) resolves index bit s-1.
- Stage s operation: takes a window of 2^s bits and splits it into lower half L and upper half U.
  - mode_high=0: if |L, bit=0 and window'=L; else bit=1 and window'=U.
  - mode_high=1: if |U, bit=1 and window'=U; else bit=0 and window'=L.
  - Each stage carries forward: window' (2^(s-1) bits), the accumulated index bits, mode_high, and hit.
- Hit flag:
  - hit = |bv_in, computed in the first stage and carried to the output.
  - If hit=0, countid is forced to 0 at the output register.
- Latency and throughput:
  - Input accepted at edge N (bv_in_valid & bv_in_ready) appears with countid_valid=1 after edge N+width_count-1, i.e. width_count cycles later, assuming no stall.
  - Throughput is one result per cycle.
- Handshake:
  - Global advance enable en = ~countid_valid | countid_ready.
  - bv_in_ready = en (combinational).
  - When en=0, every stage, including the output, holds its contents.
  - When en=1, all stages shift. A stage whose predecessor holds no valid data becomes invalid (bubble).
  - countid, countid_hit and countid_valid stay stable while countid_valid=1 & countid_ready=0.
  - No combinational path from bv_in_valid to any output.
- flush:
  - On an edge with flush=1, all stage valid bits and countid_valid clear next cycle, regardless of en.
  - An input presented in the same cycle as flush is dropped.
  - bv_in_ready is unaffected by flush.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal, with no bubble inserted.
  - reset asserted mid-operation discards all in-flight data immediately; after deassertion the first accepted input emerges normally.
- Ordering: results emerge in acceptance order. Each transaction's mode_high travels with its data; switching mode on consecutive inputs is legal.

Test Plan:
- Lowest-index mode: rule_num=64, bv_in=64'h0000_0000_0000_0120, mode_high=0, countid_ready=1 -> countid=5, hit=1, countid_valid exactly 6 cycles after acceptance.
- Highest-index mode: same vector with mode_high=1 -> countid=8, hit=1. Then bv_in=64'h8000_0000_0000_0001 with mode_high=1 -> 63, and with mode_high=0 -> 0.
- Non-power-of-two:
  - rule_num=40, width_count=6: bv_in bit 39 only, both modes -> countid=39.
  - bv_in=0 -> hit=0, countid=0.
  - All ones, mode_high=1 -> 39, never a padded index.
- Backpressure:
  - Stream 10 back-to-back vectors with one-hot k=0..9; hold countid_ready=0 for 4 cycles mid-stream.
  - -> outputs 0..9 in order, none lost or duplicated, output stable while stalled, bv_in_ready=0 during the stall once countid_valid=1.
- Flush and reset:
  - With 3 transactions in flight, pulse flush one cycle -> no result emerges. The next input emerges after width_count cycles.
  - Repeat with reset mid-stream -> countid_valid=0 immediately (asynchronously), then normal operation.
- Random: 10k random vectors with random mode and random countid_ready, checked against a reference model (first/last set bit) -> zero mismatches.
